// File: rtl/issue.sv
// issue: in-order issue with register renaming, 12 reservation-station entries and an 8-entry ROB; ISSUE_TRACE_EN prints accepted issues.
// Latency: dispatch at the earliest one cycle after issue; commit_* registered, visible the cycle after the result arrives.
// Backpressure: stall (combinational) refuses a legal instruction when the ROB is full or its station class has no free entry.
module issue (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  func,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  rd,
  output logic        stall,
  output logic [2:0]  issue_tag,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [15:0] cdb_data,
  output logic        disp_valid,
  output logic [1:0]  disp_unit,
  output logic [2:0]  disp_tag,
  output logic [3:0]  disp_op,
  output logic [15:0] disp_a,
  output logic [15:0] disp_b,
  output logic [3:0]  disp_imm,
  output logic        commit_valid,
  output logic        commit_we,
  output logic [3:0]  commit_rd,
  output logic [15:0] commit_data
);

  typedef struct packed {
    logic [15:0] value;
    logic        busy;
    logic [2:0]  tag;
  } reg_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
  } rob_t;

  typedef struct packed {
    logic        rdy;
    logic [2:0]  tag;
    logic [15:0] val;
  } opnd_t;

  typedef struct packed {
    logic        vld;
    logic [3:0]  op;
    logic [2:0]  tag;
    opnd_t       a;
    opnd_t       b;
    logic [3:0]  imm;
  } rs_t;

  // Unified station array: 0-2 ADD, 3-5 MUL, 6-7 BR, 8-11 LSQ, so index order is dispatch priority.
  localparam int NRS = 12;

  reg_t  bank_q [16];
  reg_t  bank_d [16];
  rob_t  rob_q  [8];
  rob_t  rob_d  [8];
  rs_t   rs_q   [NRS];
  rs_t   rs_d   [NRS];

  logic [2:0]  head_q, head_d, tail_q, tail_d;
  logic [3:0]  count_q, count_d;
  logic        commit_valid_q, commit_valid_d;
  logic        commit_we_q, commit_we_d;
  logic [3:0]  commit_rd_q, commit_rd_d;
  logic [15:0] commit_data_q, commit_data_d;

  logic        legal, is_ld, has_we, free_found, issue_fire, disp_found, commit_fire;
  logic [1:0]  tgt_unit;
  logic [3:0]  free_idx, disp_idx;
  logic [15:0] commit_val;
  opnd_t       opa, opb;
  rob_t        head_e;

  function automatic logic [1:0] unit_of(input int i);
    if (i < 3) return 2'd0;
    else if (i < 6) return 2'd1;
    else if (i < 8) return 2'd2;
    return 2'd3;
  endfunction

  // Operand lookup sees the pre-rename mapping and bypasses a same-cycle broadcast.
  function automatic opnd_t resolve(input reg_t r, input rob_t e, input logic cv,
                                    input logic [2:0] ct, input logic [15:0] cd);
    opnd_t o;
    o = '{rdy: 1'b1, tag: r.tag, val: r.value};
    if (r.busy) begin
      if (e.ready) o.val = e.data;
      else if (cv && ct == r.tag) o.val = cd;
      else o = '{rdy: 1'b0, tag: r.tag, val: 16'd0};
    end
    return o;
  endfunction

  always_comb begin
    legal  = ~func[3];
    is_ld  = (func == 4'b0100);
    has_we = (func[3:2] == 2'b00) || is_ld;
    case (func[2:1])
      2'b00:   tgt_unit = 2'd0;
      2'b01:   tgt_unit = 2'd1;
      2'b11:   tgt_unit = 2'd2;
      default: tgt_unit = 2'd3;
    endcase
    free_found = 1'b0;
    free_idx   = 4'd0;
    disp_found = 1'b0;
    disp_idx   = 4'd0;
    for (int i = 0; i < NRS; i++) begin
      if (!free_found && !rs_q[i].vld && unit_of(i) == tgt_unit) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
      if (!disp_found && rs_q[i].vld && rs_q[i].a.rdy && rs_q[i].b.rdy) begin
        disp_found = 1'b1;
        disp_idx   = 4'(i);
      end
    end
    stall      = in_valid && legal && (count_q == 4'd8 || !free_found);
    issue_fire = in_valid && legal && !stall;

    opa = resolve(bank_q[rs1], rob_q[bank_q[rs1].tag], cdb_valid, cdb_tag, cdb_data);
    if (is_ld) opb = '{rdy: 1'b1, tag: 3'd0, val: 16'd0};
    else opb = resolve(bank_q[rs2], rob_q[bank_q[rs2].tag], cdb_valid, cdb_tag, cdb_data);

    head_e      = rob_q[head_q];
    commit_fire = head_e.busy && (head_e.ready || (cdb_valid && cdb_tag == head_q));
    commit_val  = head_e.ready ? head_e.data : cdb_data;
  end

  always_comb begin
    bank_d         = bank_q;
    rob_d          = rob_q;
    rs_d           = rs_q;
    head_d         = head_q;
    tail_d         = tail_q;
    commit_valid_d = 1'b0;
    commit_we_d    = 1'b0;
    commit_rd_d    = 4'd0;
    commit_data_d  = 16'd0;

    if (cdb_valid) begin
      rob_d[cdb_tag].ready = 1'b1;
      rob_d[cdb_tag].data  = cdb_data;
      for (int i = 0; i < NRS; i++) begin
        if (rs_q[i].vld && !rs_q[i].a.rdy && rs_q[i].a.tag == cdb_tag)
          rs_d[i].a = '{rdy: 1'b1, tag: cdb_tag, val: cdb_data};
        if (rs_q[i].vld && !rs_q[i].b.rdy && rs_q[i].b.tag == cdb_tag)
          rs_d[i].b = '{rdy: 1'b1, tag: cdb_tag, val: cdb_data};
      end
    end

    if (disp_found) rs_d[disp_idx].vld = 1'b0;

    if (commit_fire) begin
      rob_d[head_q].busy  = 1'b0;
      rob_d[head_q].ready = 1'b0;
      commit_valid_d      = 1'b1;
      commit_we_d         = head_e.we;
      commit_rd_d         = head_e.rd;
      commit_data_d       = commit_val;
      if (head_e.we) begin
        bank_d[head_e.rd].value = commit_val;
        if (bank_q[head_e.rd].tag == head_q) bank_d[head_e.rd].busy = 1'b0;
      end
      head_d = head_q + 3'd1;
    end

    // Rename after commit so a same-cycle commit to rd cannot clear the new mapping.
    if (issue_fire) begin
      rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, we: has_we, rd: rd, data: 16'd0};
      rs_d[free_idx] = '{vld: 1'b1, op: func, tag: tail_q, a: opa, b: opb,
                         imm: (tgt_unit == 2'd2) ? rd : 4'd0};
      if (has_we) begin
        bank_d[rd].busy = 1'b1;
        bank_d[rd].tag  = tail_q;
      end
      tail_d = tail_q + 3'd1;
    end

    count_d = count_q + {3'd0, issue_fire} - {3'd0, commit_fire};
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank_q[i] <= '{value: 16'(i), busy: 1'b0, tag: 3'd0};
      for (int i = 0; i < 8; i++) rob_q[i] <= '0;
      for (int i = 0; i < NRS; i++) rs_q[i] <= '0;
      head_q         <= 3'd0;
      tail_q         <= 3'd0;
      count_q        <= 4'd0;
      commit_valid_q <= 1'b0;
      commit_we_q    <= 1'b0;
      commit_rd_q    <= 4'd0;
      commit_data_q  <= 16'd0;
    end else begin
      bank_q         <= bank_d;
      rob_q          <= rob_d;
      rs_q           <= rs_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_we_q    <= commit_we_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
    end
  end

  always_comb begin
    disp_valid = disp_found;
    disp_unit  = 2'd0;
    disp_tag   = 3'd0;
    disp_op    = 4'd0;
    disp_a     = 16'd0;
    disp_b     = 16'd0;
    disp_imm   = 4'd0;
    if (disp_found) begin
      disp_unit = unit_of(int'(disp_idx));
      disp_tag  = rs_q[disp_idx].tag;
      disp_op   = rs_q[disp_idx].op;
      disp_a    = rs_q[disp_idx].a.val;
      disp_b    = rs_q[disp_idx].b.val;
      disp_imm  = rs_q[disp_idx].imm;
    end
  end

  assign issue_tag    = tail_q;
  assign commit_valid = commit_valid_q;
  assign commit_we    = commit_we_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;

`ifdef ISSUE_TRACE_EN
  always_ff @(posedge clk1) begin
    if (rst_n && issue_fire)
      $display("issue func=%b rs1=%b rs2=%b rd=%b tag=%b", func, rs1, rs2, rd, tail_q);
  end
`endif

endmodule

// File: tb/tb_issue.sv
// Directed bench for issue: reset, rename/wakeup, station and ROB full, branches, mid-flight reset.
module tb_issue;
  logic        clk1, rst_n, in_valid, stall, cdb_valid, disp_valid;
  logic [3:0]  func, rs1, rs2, rd, disp_op, disp_imm, commit_rd;
  logic [2:0]  issue_tag, cdb_tag, disp_tag;
  logic [15:0] cdb_data, disp_a, disp_b, commit_data;
  logic [1:0]  disp_unit;
  logic        commit_valid, commit_we;
  int          n_cmp = 0;
  int          n_err = 0;

  issue dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .func(func), .rs1(rs1), .rs2(rs2), .rd(rd),
    .stall(stall), .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_tag(disp_tag),
    .disp_op(disp_op), .disp_a(disp_a), .disp_b(disp_b), .disp_imm(disp_imm),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_data(commit_data)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; func = 4'd0; rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0;
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'd0;
  endtask

  task automatic ins(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    in_valid = 1'b1; func = f; rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  // Advance to just after the next rising edge, clearing inputs.
  task automatic tick();
    @(posedge clk1);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_issue_tag", issue_tag, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_we", commit_we, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_commit_data", commit_data, 0);

    // add r1,r2->r3; broadcast result 3; then r3 reads committed value
    do_reset();
    ins(4'b0000, 4'd1, 4'd2, 4'd3); #1;
    check("A_stall", stall, 0);
    check("A_tag0", issue_tag, 0);
    tick();
    check("A_disp_valid", disp_valid, 1);
    check("A_disp_unit", disp_unit, 0);
    check("A_disp_a", disp_a, 1);
    check("A_disp_b", disp_b, 2);
    check("A_disp_tag", disp_tag, 0);
    cdb(3'd0, 16'd3);
    tick();
    check("A_commit_valid", commit_valid, 1);
    check("A_commit_we", commit_we, 1);
    check("A_commit_rd", commit_rd, 3);
    check("A_commit_data", commit_data, 3);
    check("A_disp_freed", disp_valid, 0);
    ins(4'b0000, 4'd3, 4'd0, 4'd5); #1;
    check("A_tag1", issue_tag, 1);
    tick();
    check("A_r3_ready_valid", disp_valid, 1);
    check("A_r3_value", disp_a, 3);
    check("A_commit_pulse", commit_valid, 0);

    // mul r1,r2->r4 then add r4,r1->r5 waits for the broadcast
    do_reset();
    ins(4'b0010, 4'd1, 4'd2, 4'd4);
    tick();
    check("B_mul_unit", disp_unit, 1);
    check("B_mul_op", disp_op, 2);
    ins(4'b0000, 4'd4, 4'd1, 4'd5); #1;
    check("B_add_tag", issue_tag, 1);
    tick();
    check("B_add_waits", disp_valid, 0);
    cdb(3'd0, 16'd2);
    tick();
    check("B_add_disp", disp_valid, 1);
    check("B_add_unit", disp_unit, 0);
    check("B_add_a", disp_a, 2);
    check("B_add_b", disp_b, 1);
    check("B_add_dtag", disp_tag, 1);
    check("B_commit_rd", commit_rd, 4);
    check("B_commit_data", commit_data, 2);
    tick();
    check("B_no_commit", commit_valid, 0);
    cdb(3'd1, 16'hBEEF);
    tick();
    check("B_commit2_valid", commit_valid, 1);
    check("B_commit2_rd", commit_rd, 5);
    check("B_commit2_data", commit_data, 16'hBEEF);
    ins(4'b0000, 4'd5, 4'd4, 4'd6);
    tick();
    check("B_r5_a", disp_a, 16'hBEEF);
    check("B_r4_b", disp_b, 2);

    // ADD station full, then ROB full with tail wrap
    do_reset();
    ins(4'b0000, 4'd1, 4'd2, 4'd6);
    tick();
    ins(4'b0000, 4'd6, 4'd6, 4'd7);
    tick();
    ins(4'b0001, 4'd6, 4'd1, 4'd7);
    tick();
    ins(4'b0000, 4'd6, 4'd2, 4'd8); #1;
    check("C_third_wait_ok", stall, 0);
    tick();
    ins(4'b0000, 4'd1, 4'd1, 4'd9); #1;
    check("C_add_full_stall", stall, 1);
    check("C_add_full_tag", issue_tag, 4);
    check("C_no_disp", disp_valid, 0);
    tick();
    ins(4'b0010, 4'd1, 4'd2, 4'd9); #1;
    check("C_mul_ok", stall, 0);
    check("C_mul_tag", issue_tag, 4);
    tick();
    check("C_mul_disp_unit", disp_unit, 1);
    ins(4'b0110, 4'd6, 4'd1, 4'd5);
    tick();
    ins(4'b0100, 4'd1, 4'd0, 4'd10);
    tick();
    ins(4'b0101, 4'd2, 4'd3, 4'd0); #1;
    check("C_st_tag", issue_tag, 7);
    check("C_ld_unit", disp_unit, 3);
    check("C_ld_a", disp_a, 1);
    check("C_ld_b", disp_b, 0);
    tick();
    ins(4'b0100, 4'd1, 4'd0, 4'd11); #1;
    check("C_rob_full_stall", stall, 1);
    check("C_tail_wrap", issue_tag, 0);
    check("C_st_a", disp_a, 2);
    check("C_st_b", disp_b, 3);
    tick();
    cdb(3'd0, 16'd7);
    tick();
    check("C_commit_rd", commit_rd, 6);
    check("C_commit_data", commit_data, 7);
    check("C_wake_tag", disp_tag, 2);
    check("C_wake_a", disp_a, 7);
    check("C_wake_b", disp_b, 1);
    ins(4'b0100, 4'd1, 4'd0, 4'd11); #1;
    check("C_after_commit_stall", stall, 0);
    check("C_after_commit_tag", issue_tag, 0);
    tick();
    check("C_next_tag", disp_tag, 1);
    check("C_next_b", disp_b, 7);

    // illegal func discarded; beq carries rd as immediate and commits without a write
    do_reset();
    ins(4'b1010, 4'd1, 4'd2, 4'd3); #1;
    check("D_illegal_stall", stall, 0);
    tick();
    check("D_no_alloc", issue_tag, 0);
    check("D_no_disp", disp_valid, 0);
    ins(4'b0110, 4'd1, 4'd2, 4'd5);
    tick();
    check("D_br_unit", disp_unit, 2);
    check("D_br_imm", disp_imm, 5);
    check("D_br_op", disp_op, 6);
    cdb(3'd0, 16'd0);
    tick();
    check("D_br_commit", commit_valid, 1);
    check("D_br_we", commit_we, 0);

    // reset with instructions in flight
    do_reset();
    ins(4'b0000, 4'd1, 4'd2, 4'd3);
    tick();
    ins(4'b0000, 4'd3, 4'd3, 4'd4);
    tick();
    ins(4'b0010, 4'd4, 4'd1, 4'd5);
    tick();
    cdb(3'd0, 16'd9);
    tick();
    check("E_pre_commit", commit_valid, 1);
    check("E_pre_data", commit_data, 9);
    check("E_pre_disp", disp_valid, 1);
    rst_n = 1'b0; #1;
    check("E_rst_commit", commit_valid, 0);
    check("E_rst_data", commit_data, 0);
    check("E_rst_rd", commit_rd, 0);
    check("E_rst_disp", disp_valid, 0);
    check("E_rst_tag", issue_tag, 0);
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    ins(4'b0000, 4'd3, 4'd4, 4'd5); #1;
    check("E_tag_restart", issue_tag, 0);
    tick();
    check("E_bank_a", disp_a, 3);
    check("E_bank_b", disp_b, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
